// File: rtl/mem_bus_adapter.sv
// Sized core memory port to word-wide byte-enabled bus adapter.
// Byte/half/word accesses become one or two word-aligned bus beats; read data returns right-aligned.
module mem_bus_adapter #(
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RESP
    } state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 4'b0001;
            SIZE_HALF: return 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] keep_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 32'h0000_00FF;
            SIZE_HALF: return 32'h0000_FFFF;
            default:   return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 4'd1;
            SIZE_HALF: return 4'd2;
            default:   return 4'd4;
        endcase
    endfunction

    function automatic logic crosses_word(input logic [1:0] off, input logic [1:0] size);
        return ({2'b00, off} + size_bytes(size)) > 4'd4;
    endfunction

    state_t      state_q;
    logic        ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;

    logic        we_q;
    logic        split_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic [29:0] word_q;
    logic [3:0]  be1_q;
    logic [31:0] wdata1_q;
    logic [31:0] d0_q;

    // Lane placement of the incoming request; the upper half feeds the second beat.
    logic [7:0]  be_full_d;
    logic [63:0] wdata_full_d;
    logic        split_d;
    logic        reject_d;

    assign be_full_d    = {4'b0000, size_mask(req_size_i)} << req_addr_i[1:0];
    assign wdata_full_d = {32'h0000_0000, req_wdata_i} << {req_addr_i[1:0], 3'b000};
    assign split_d      = crosses_word(req_addr_i[1:0], req_size_i);
    assign reject_d     = split_d && (ALLOW_MISALIGNED == 0);

    logic [31:0] rdata_single;
    logic [31:0] rdata_split;

    assign rdata_single = (bus_rdata_i >> {off_q, 3'b000}) & keep_mask(size_q);
    assign rdata_split  = 32'({bus_rdata_i, d0_q} >> {off_q, 3'b000}) & keep_mask(size_q);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            we_q        <= 1'b0;
            split_q     <= 1'b0;
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            word_q      <= 30'h0;
            be1_q       <= 4'h0;
            wdata1_q    <= 32'h0;
            d0_q        <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        ready_q  <= 1'b0;
                        we_q     <= req_we_i;
                        split_q  <= split_d;
                        off_q    <= req_addr_i[1:0];
                        size_q   <= req_size_i;
                        word_q   <= req_addr_i[31:2];
                        be1_q    <= be_full_d[7:4];
                        wdata1_q <= wdata_full_d[63:32];
                        if (reject_d) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            state_q     <= S_REQ0;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= req_we_i;
                            bus_addr_q  <= {req_addr_i[31:2], 2'b00};
                            bus_be_q    <= be_full_d[3:0];
                            bus_wdata_q <= wdata_full_d[31:0];
                        end
                    end
                end

                S_REQ0: begin
                    if (bus_gnt_i) begin
                        if (we_q && split_q) begin
                            // Back-to-back write beats keep bus_req_o high across the switch.
                            state_q     <= S_REQ1;
                            bus_addr_q  <= {word_q + 30'd1, 2'b00};
                            bus_be_q    <= be1_q;
                            bus_wdata_q <= wdata1_q;
                        end else begin
                            bus_req_q   <= 1'b0;
                            bus_we_q    <= 1'b0;
                            bus_addr_q  <= 32'h0;
                            bus_be_q    <= 4'h0;
                            bus_wdata_q <= 32'h0;
                            if (we_q) begin
                                state_q     <= S_RESP;
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= 1'b0;
                                rsp_rdata_q <= 32'h0;
                            end else begin
                                state_q <= S_WAIT0;
                            end
                        end
                    end
                end

                S_WAIT0: begin
                    if (bus_rvalid_i) begin
                        d0_q <= bus_rdata_i;
                        if (split_q) begin
                            state_q     <= S_REQ1;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= 1'b0;
                            bus_addr_q  <= {word_q + 30'd1, 2'b00};
                            bus_be_q    <= be1_q;
                            bus_wdata_q <= wdata1_q;
                        end else begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= rdata_single;
                        end
                    end
                end

                S_REQ1: begin
                    if (bus_gnt_i) begin
                        bus_req_q   <= 1'b0;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= 32'h0;
                        bus_be_q    <= 4'h0;
                        bus_wdata_q <= 32'h0;
                        if (we_q) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            state_q <= S_WAIT1;
                        end
                    end
                end

                S_WAIT1: begin
                    if (bus_rvalid_i) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= rdata_split;
                    end
                end

                S_RESP: begin
                    state_q     <= S_IDLE;
                    ready_q     <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                end

                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_be_o    = bus_be_q;
    assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_adapter.sv
// Self-checking bench for mem_bus_adapter: directed vectors, corner sequences and a
// randomized run against a byte-addressed memory model.
module tb_mem_bus_adapter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_ni;
    logic        req_valid, req_valid_na, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    logic        req_ready_o, rsp_valid_o, rsp_err_o, bus_req_o, bus_we_o;
    logic [31:0] rsp_rdata_o, bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;

    logic        na_ready, na_rsp_valid, na_rsp_err, na_bus_req, na_bus_we;
    logic [31:0] na_rsp_rdata, na_bus_addr, na_bus_wdata;
    logic [3:0]  na_bus_be;

    mem_bus_adapter #(.ALLOW_MISALIGNED(1)) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_size_i(req_size), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
    );

    mem_bus_adapter #(.ALLOW_MISALIGNED(0)) dut_na (
        .clk_i(clk), .reset_ni(reset_ni),
        .req_valid_i(req_valid_na), .req_ready_o(na_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_size_i(req_size), .req_wdata_i(req_wdata),
        .rsp_valid_o(na_rsp_valid), .rsp_rdata_o(na_rsp_rdata), .rsp_err_o(na_rsp_err),
        .bus_req_o(na_bus_req), .bus_gnt_i(bus_gnt), .bus_we_o(na_bus_we),
        .bus_addr_o(na_bus_addr), .bus_be_o(na_bus_be), .bus_wdata_o(na_bus_wdata),
        .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Slave-side memory (updated by bus beats) and reference memory (updated per core byte).
    logic [7:0] smem [logic [31:0]];
    logic [7:0] mmem [logic [31:0]];

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] sget(input logic [31:0] a);
        if (smem.exists(a)) return smem[a];
        return dflt(a);
    endfunction

    function automatic logic [7:0] mget(input logic [31:0] a);
        if (mmem.exists(a)) return mmem[a];
        return dflt(a);
    endfunction

    function automatic logic [31:0] be_bits(input logic [3:0] be);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{be[k]}};
        return m;
    endfunction

    task automatic preload(input logic [31:0] wa, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            smem[wa + k] = w[8*k +: 8];
            mmem[wa + k] = w[8*k +: 8];
        end
    endtask

    // Reference: walk the accessed bytes, group them by containing word.
    int          exp_n;
    logic [31:0] exp_addr [2];
    logic [3:0]  exp_be [2];
    logic [31:0] exp_wd [2];
    logic [31:0] exp_rdata;

    task automatic model_access(input logic we, input logic [31:0] addr,
                                input logic [1:0] size, input logic [31:0] wdata);
        int n;
        logic [31:0] ba, w;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        exp_n = 0;
        exp_rdata = 32'h0;
        for (int i = 0; i < n; i++) begin
            ba = addr + i;
            w  = {ba[31:2], 2'b00};
            if (exp_n == 0 || exp_addr[exp_n-1] != w) begin
                exp_addr[exp_n] = w;
                exp_be[exp_n]   = 4'h0;
                exp_wd[exp_n]   = 32'h0;
                exp_n++;
            end
            exp_be[exp_n-1][ba[1:0]] = 1'b1;
            exp_wd[exp_n-1][8*ba[1:0] +: 8] = wdata[8*i +: 8];
            if (we) mmem[ba] = wdata[8*i +: 8];
            else    exp_rdata[8*i +: 8] = mget(ba);
        end
    endtask

    int          obs_n;
    logic [31:0] obs_addr [4];
    logic [3:0]  obs_be [4];
    logic [31:0] obs_wd [4];
    logic [31:0] obs_rdata;
    logic        obs_err;
    int          obs_lat;

    // Issue one request and act as the bus slave until the response pulse.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] wdata, input int gd, input int rd, input bit noise);
        int c, waitn, rv_cyc;
        bit pend, seen, done;
        logic [31:0] sa, sw, word;
        logic [3:0] sb;
        logic swe;
        obs_n = 0; obs_lat = -1; obs_rdata = 32'h0; obs_err = 1'b0;
        waitn = 0; rv_cyc = 0; word = 32'h0; sa = 32'h0; sw = 32'h0; sb = 4'h0; swe = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom); req_wdata = $urandom;
        c = 1; pend = 0; seen = 0; done = 0;
        while (!done && c < 200) begin
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
            if (rsp_valid_o) begin
                obs_lat = c; obs_rdata = rsp_rdata_o; obs_err = rsp_err_o; done = 1;
            end else if (pend && c == rv_cyc) begin
                bus_rvalid = 1'b1; bus_rdata = word; pend = 0;
            end else if (bus_req_o) begin
                if (!seen) begin
                    seen = 1; waitn = 0;
                    sa = bus_addr_o; sb = bus_be_o; sw = bus_wdata_o; swe = bus_we_o;
                end else begin
                    chk("stall_addr", bus_addr_o, sa);
                    chk("stall_be", {28'h0, bus_be_o}, {28'h0, sb});
                    chk("stall_wdata", bus_wdata_o, sw);
                    chk("stall_we", {31'h0, bus_we_o}, {31'h0, swe});
                end
                if (waitn < gd) begin
                    waitn++;
                    if (noise) bus_rvalid = 1'($urandom);
                end else begin
                    bus_gnt = 1'b1; seen = 0;
                    if (obs_n < 4) begin
                        obs_addr[obs_n] = bus_addr_o; obs_be[obs_n] = bus_be_o; obs_wd[obs_n] = bus_wdata_o;
                    end
                    obs_n++;
                    if (bus_we_o) begin
                        for (int k = 0; k < 4; k++)
                            if (bus_be_o[k]) smem[bus_addr_o + k] = bus_wdata_o[8*k +: 8];
                    end else begin
                        for (int k = 0; k < 4; k++) word[8*k +: 8] = sget(bus_addr_o + k);
                        pend = 1; rv_cyc = c + rd;
                    end
                end
            end else if (noise) begin
                bus_gnt = 1'($urandom);
                if (!pend) bus_rvalid = 1'($urandom);
            end
            if (!done) begin
                @(posedge clk);
                @(negedge clk);
                c++;
            end
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout: no rsp_valid_o within %0d cycles", c);
        end else begin
            @(posedge clk);
            @(negedge clk);
            chk("rsp_pulse_drop", {31'h0, rsp_valid_o}, 32'h0);
            chk("ready_after", {31'h0, req_ready_o}, 32'h1);
        end
    endtask

    task automatic run_model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] wdata, input int gd, input int rd, input bit noise);
        model_access(we, addr, size, wdata);
        do_access(we, addr, size, wdata, gd, rd, noise);
        chk("m_nbeats", obs_n, exp_n);
        for (int k = 0; k < exp_n; k++) begin
            if (k < obs_n) begin
                chk("m_addr", obs_addr[k], exp_addr[k]);
                chk("m_be", {28'h0, obs_be[k]}, {28'h0, exp_be[k]});
                if (we) chk("m_wdata", obs_wd[k] & be_bits(obs_be[k]), exp_wd[k]);
            end
        end
        chk("m_rdata", obs_rdata, exp_rdata);
        chk("m_err", {31'h0, obs_err}, 32'h0);
        chk("m_latency", obs_lat, 1 + exp_n * (gd + 1 + (we ? 0 : rd)));
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] pre0, pre1;
        int          nb;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{1'b0, 32'h100, 2'd2, 32'h0, 32'hDEADBEEF, 32'h0, 1, 32'h100, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 3};
        vecs[1] = '{1'b1, 32'h203, 2'd0, 32'hA5, 32'h0, 32'h0, 1, 32'h200, 4'h8, 32'hA5000000, 32'h0, 4'h0, 32'h0, 32'h0, 2};
        vecs[2] = '{1'b0, 32'h103, 2'd1, 32'h0, 32'h11223344, 32'h55667788, 2, 32'h100, 4'h8, 32'h0, 32'h104, 4'h1, 32'h0, 32'h00008811, 5};
        vecs[3] = '{1'b1, 32'h102, 2'd2, 32'hAABBCCDD, 32'h0, 32'h0, 2, 32'h100, 4'hC, 32'hCCDD0000, 32'h104, 4'h3, 32'h0000AABB, 32'h0, 3};
        vecs[4] = '{1'b0, 32'hFFFFFFFE, 2'd2, 32'h0, 32'h01020304, 32'hA0B0C0D0, 2, 32'hFFFFFFFC, 4'hC, 32'h0, 32'h0, 4'h3, 32'h0, 32'hC0D00102, 5};
        vecs[5] = '{1'b0, 32'h105, 2'd0, 32'h0, 32'h55667788, 32'h0, 1, 32'h104, 4'h2, 32'h0, 32'h0, 4'h0, 32'h0, 32'h00000077, 3};
        vecs[6] = '{1'b1, 32'h302, 2'd1, 32'h1234BEEF, 32'h0, 32'h0, 1, 32'h300, 4'hC, 32'hBEEF0000, 32'h0, 4'h0, 32'h0, 32'h0, 2};
        vecs[7] = '{1'b0, 32'h106, 2'd1, 32'h0, 32'h55667788, 32'h0, 1, 32'h104, 4'hC, 32'h0, 32'h0, 4'h0, 32'h0, 32'h00005566, 3};
        vecs[8] = '{1'b1, 32'h1FF, 2'd1, 32'h00009A7B, 32'h0, 32'h0, 2, 32'h1FC, 4'h8, 32'h7B000000, 32'h200, 4'h1, 32'h0000009A, 32'h0, 3};

        reset_ni = 1'b0;
        req_valid = 1'b0; req_valid_na = 1'b0; req_we = 1'b0;
        req_addr = 32'h0; req_size = 2'd0; req_wdata = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        repeat (3) @(negedge clk);

        chk("rst_bus_req", {31'h0, bus_req_o}, 32'h0);
        chk("rst_bus_we", {31'h0, bus_we_o}, 32'h0);
        chk("rst_bus_addr", bus_addr_o, 32'h0);
        chk("rst_bus_be", {28'h0, bus_be_o}, 32'h0);
        chk("rst_bus_wdata", bus_wdata_o, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err_o}, 32'h0);
        chk("rst_ready", {31'h0, req_ready_o}, 32'h1);
        reset_ni = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            if (!vecs[i].we) begin
                preload(vecs[i].a0, vecs[i].pre0);
                if (vecs[i].nb == 2) preload(vecs[i].a1, vecs[i].pre1);
            end
            model_access(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata);
            do_access(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].wdata, 0, 1, 1'b0);
            chk($sformatf("vec%0d_nbeats", i), obs_n, vecs[i].nb);
            chk($sformatf("vec%0d_addr0", i), obs_addr[0], vecs[i].a0);
            chk($sformatf("vec%0d_be0", i), {28'h0, obs_be[0]}, {28'h0, vecs[i].be0});
            if (vecs[i].we) chk($sformatf("vec%0d_wdata0", i), obs_wd[0], vecs[i].wd0);
            if (vecs[i].nb == 2) begin
                chk($sformatf("vec%0d_addr1", i), obs_addr[1], vecs[i].a1);
                chk($sformatf("vec%0d_be1", i), {28'h0, obs_be[1]}, {28'h0, vecs[i].be1});
                if (vecs[i].we) chk($sformatf("vec%0d_wdata1", i), obs_wd[1], vecs[i].wd1);
            end
            chk($sformatf("vec%0d_rdata", i), obs_rdata, vecs[i].rdata);
            chk($sformatf("vec%0d_err", i), {31'h0, obs_err}, 32'h0);
            chk($sformatf("vec%0d_latency", i), obs_lat, vecs[i].lat);
        end

        // Grant withheld five cycles: outputs held, latency stretched.
        run_model(1'b1, 32'h400, 2'd2, 32'h13579BDF, 5, 1, 1'b0);
        chk("stall_write_be", {28'h0, obs_be[0]}, 32'hF);
        chk("stall_write_wdata", obs_wd[0], 32'h13579BDF);
        run_model(1'b0, 32'h403, 2'd1, 32'h0, 5, 3, 1'b1);

        // Misaligned word read with splitting disabled: immediate error, no bus request.
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h101; req_size = 2'd2; req_wdata = 32'h0; req_valid_na = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_na = 1'b0;
        chk("na_rsp_valid", {31'h0, na_rsp_valid}, 32'h1);
        chk("na_rsp_err", {31'h0, na_rsp_err}, 32'h1);
        chk("na_rsp_rdata", na_rsp_rdata, 32'h0);
        chk("na_bus_req", {31'h0, na_bus_req}, 32'h0);
        @(negedge clk);
        chk("na_rsp_drop", {31'h0, na_rsp_valid}, 32'h0);
        chk("na_ready", {31'h0, na_ready}, 32'h1);
        chk("na_bus_req_after", {31'h0, na_bus_req}, 32'h0);

        // Reset asserted while waiting for read data; the late rvalid must be ignored.
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h100; req_size = 2'd2; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rw_bus_req", {31'h0, bus_req_o}, 32'h1);
        bus_gnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_gnt = 1'b0;
        chk("rw_wait_ready", {31'h0, req_ready_o}, 32'h0);
        reset_ni = 1'b0;
        #1;
        chk("rw_async_bus_req", {31'h0, bus_req_o}, 32'h0);
        chk("rw_async_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        chk("rw_async_ready", {31'h0, req_ready_o}, 32'h1);
        @(negedge clk);
        reset_ni = 1'b1;
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
        @(negedge clk);
        bus_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rw_late_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
            chk("rw_late_bus_req", {31'h0, bus_req_o}, 32'h0);
            @(negedge clk);
        end
        chk("rw_late_ready", {31'h0, req_ready_o}, 32'h1);

        for (int i = 0; i < 120; i++) begin
            logic        we;
            logic [1:0]  size;
            logic [31:0] addr;
            we   = 1'($urandom);
            size = 2'($urandom_range(0, 2));
            addr = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + $urandom_range(0, 15)
                                               : 32'h1000 + $urandom_range(0, 31);
            run_model(we, addr, size, $urandom, $urandom_range(0, 3), $urandom_range(1, 3), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_adapter.md
# mem_bus_adapter

Sits between the core datapath's sized memory port and a word-wide, byte-enabled system bus with a request/grant/rvalid handshake. Accepts one byte, halfword or word access at a time and converts it into one or two word-aligned bus transactions, splitting accesses that cross a word boundary. Returns read data right-aligned and zero-extended, because the datapath performs sign extension. Holds off the core with `req_ready_o` until the access completes.

## Interface
Parameters:
- `ALLOW_MISALIGNED`, default 1. When 1, word-crossing accesses are split into two transactions. When 0, they are rejected with an error.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `reset_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: core request valid.
- `req_ready_o` out 1: adapter can accept a request.
- `req_we_i` in 1: 1 = write, 0 = read.
- `req_addr_i` in 32: byte address.
- `req_size_i` in `mem_access_size_t`: BYTE, HALF or WORD.
- `req_wdata_i` in 32: write data, right-aligned.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_rdata_o` out 32: read data, right-aligned, zero-extended. 0 for writes and errors.
- `rsp_err_o` out 1: misaligned access rejected. Valid with `rsp_valid_o`.
- `bus_req_o` out 1: bus request.
- `bus_gnt_i` in 1: bus grant.
- `bus_we_o` out 1: bus write.
- `bus_addr_o` out 32: word-aligned address, bits [1:0] always 0.
- `bus_be_o` out 4: byte enables.
- `bus_wdata_o` out 32: lane-aligned write data.
- `bus_rvalid_i` in 1: read data valid.
- `bus_rdata_i` in 32: read data.

## Operation
- **States:** IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- **Accept:** a request is accepted on a rising edge where `req_valid_i && req_ready_o`. Address, size, we and wdata are registered; the inputs are not used again.
- **Ready:** `req_ready_o` = (state == IDLE).
- **Sizing:** n = 1, 2 or 4 bytes; off = addr[1:0]; mask = 4'b0001, 4'b0011 or 4'b1111. Access is split when off + n > 4.
- **Misaligned, ALLOW_MISALIGNED=0:** IDLE → RESP directly with `rsp_err_o`=1 and no bus activity.
- **Beat 0:**
  - `bus_addr_o` = {addr[31:2], 2'b00}.
  - `bus_be_o` = (mask << off)[3:0].
  - `bus_wdata_o` = wdata << 8·off.
- **Beat 1 (split only):**
  - `bus_addr_o` = beat-0 address + 4; wraps modulo 2^32 (0xFFFFFFFC → 0x00000000).
  - `bus_be_o` = mask >> (4 − off).
  - `bus_wdata_o` = wdata >> 8·(4 − off).
- **REQx:** `bus_req_o`=1. Address, be, we and wdata are held stable until `bus_gnt_i`=1. Transitions on grant:
  - Read: → WAITx.
  - Write, first of split: → REQ1.
  - Write, last beat: → RESP.
- **WAITx:** waits for `bus_rvalid_i` and captures `bus_rdata_i` as d0 or d1.
  - WAIT0 → REQ1 if split, else → RESP.
  - WAIT1 → RESP.
- **Read assembly:**
  - Non-split: (d0 >> 8·off), masked to n bytes.
  - Split: ({d1, d0} >> 8·off)[31:0], masked to n bytes.
  - Upper bytes are 0.
- **RESP:** `rsp_valid_o`=1 for exactly one cycle, then → IDLE.
- **Ignored inputs:** `bus_rvalid_i` outside WAITx; `bus_gnt_i` outside REQx.
- **Reset:** asynchronous assertion aborts any transaction. State → IDLE; `bus_req_o`, `rsp_valid_o` and `rsp_err_o` drop immediately. A late `bus_rvalid_i` from the aborted read is ignored.

## Timing
- **Reset values:**
  - 0: `bus_req_o`, `bus_we_o`, `bus_addr_o`, `bus_be_o`, `bus_wdata_o`, `rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o`.
  - 1: `req_ready_o` (IDLE).
- **Bus-driven outputs:** `bus_*` are 0 outside REQx states.
- **Accept:** request accepted at edge 0. `bus_req_o` is high in cycle 1 at the earliest.
- **Grant:** may arrive in the same cycle `bus_req_o` rises. `rvalid` arrives no earlier than the cycle after grant.
- **Aligned read, best case:** grant cycle 1, rvalid cycle 2, `rsp_valid_o` cycle 3, `req_ready_o` high cycle 4.
- **Aligned write, best case:** grant cycle 1, `rsp_valid_o` cycle 2.
- **Split read, best case:** `rsp_valid_o` cycle 5. Split write, best case: cycle 3.
- **Stability:** `rsp_rdata_o` and `rsp_err_o` are registered and stable during the `rsp_valid_o` cycle.
- **Throughput:** no pipelining; at most one request is in flight.

## Test plan
- **Aligned word read:** addr 0x100, gnt immediate, rvalid next cycle with 0xDEADBEEF.
  - Bus: `bus_addr_o`=0x100, `bus_be_o`=4'hF.
  - Response: `rsp_rdata_o`=0xDEADBEEF, `rsp_valid_o` in cycle 3.
- **Byte write:** addr 0x203, wdata 0x000000A5.
  - Bus: `bus_addr_o`=0x200, `bus_be_o`=4'h8, `bus_wdata_o`=0xA5000000.
  - Response: single beat, `rsp_valid_o` after grant.
- **Split halfword read:** addr 0x103; beat 0 returns 0x11223344, beat 1 returns 0x55667788.
  - Bus: beats at 0x100 with be 4'h8, then 0x104 with be 4'h1.
  - Response: `rsp_rdata_o`=0x00008811.
- **Split word write:** addr 0x102, wdata 0xAABBCCDD.
  - Beat 0: be 4'hC, wdata 0xCCDD0000.
  - Beat 1: 0x104, be 4'h3, wdata 0x0000AABB.
- **Grant stall and wrap:**
  - Grant withheld 5 cycles: bus outputs remain constant throughout.
  - Split word read at 0xFFFFFFFE: beat 1 address 0x00000000.
- **ALLOW_MISALIGNED=0:** word read at 0x101 gives no `bus_req_o` and `rsp_err_o`=1 with `rsp_rdata_o`=0.
- **Reset in WAIT0:** assert `reset_ni` low, then deliver rvalid after release.
  - `bus_req_o` and `rsp_valid_o` stay 0 and the late rvalid is ignored.
  - `req_ready_o`=1.
